// File: rtl/bus_stability_filter_pkg.sv
// Shared types for the bus stability filter: FSM state encoding and counter sizing.
package bus_stability_filter_pkg;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    SETTLE = 2'd2
  } bsf_state_t;

  // Counter must be able to hold the value STABLE_CYCLES itself.
  function automatic int bsf_cnt_width(input int stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction

endpackage

// File: rtl/saturating_counter.sv
// Up-counter that sticks at all-ones; one cycle from inc to count, no backpressure.
module saturating_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/bus_stability_filter.sv
// Commits a synchronised bus word once it holds for STABLE_CYCLES samples; out/update are
// visible the cycle after the committing edge. Samples every cycle, no backpressure.
module bus_stability_filter
  import bus_stability_filter_pkg::*;
#(
  parameter int               WIDTH            = 8,
  parameter int               STABLE_CYCLES    = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE      = '0,
  parameter int               GLITCH_CNT_WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH-1:0]            in_sync,
  output logic [WIDTH-1:0]            out,
  output logic                        out_valid,
  output logic                        update,
  output logic                        unstable,
  output logic [GLITCH_CNT_WIDTH-1:0] glitch_count
);

  localparam int            CW         = bsf_cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] STABLE_CNT = CW'(STABLE_CYCLES);

  bsf_state_t       r_state;
  logic [WIDTH-1:0] r_candidate;
  logic [WIDTH-1:0] r_out;
  logic [CW-1:0]    r_cnt;
  logic             r_out_valid;
  logic             r_update;

  logic [CW-1:0]    w_cnt_inc;
  logic             w_init_restart;
  logic [CW-1:0]    w_init_cnt;
  logic             w_glitch_inc;

  assign w_cnt_inc      = r_cnt + CW'(1);
  assign w_init_restart = (in_sync != r_candidate) || (r_cnt == '0);
  assign w_init_cnt     = w_init_restart ? CW'(1) : w_cnt_inc;

  // A settle is aborted either by reverting to the committed word or by a further change.
  assign w_glitch_inc = (r_state == SETTLE) &&
                        ((in_sync == r_out) || (in_sync != r_candidate));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= INIT;
      r_candidate <= '0;
      r_cnt       <= '0;
      r_out       <= RESET_VALUE;
      r_out_valid <= 1'b0;
      r_update    <= 1'b0;
    end else begin
      r_update <= 1'b0;
      case (r_state)
        INIT: begin
          // Whether restarting or extending the run, the candidate equals the sample.
          r_candidate <= in_sync;
          r_cnt       <= w_init_cnt;
          if (w_init_cnt == STABLE_CNT) begin
            r_out       <= in_sync;
            r_out_valid <= 1'b1;
            r_update    <= (in_sync != RESET_VALUE);
            r_state     <= IDLE;
          end
        end
        IDLE: begin
          if (in_sync != r_out) begin
            r_candidate <= in_sync;
            r_cnt       <= CW'(1);
            if (STABLE_CYCLES == 1) begin
              r_out    <= in_sync;
              r_update <= 1'b1;
            end else begin
              r_state <= SETTLE;
            end
          end
        end
        SETTLE: begin
          if (in_sync == r_out) begin
            r_state <= IDLE;
          end else if (in_sync != r_candidate) begin
            r_candidate <= in_sync;
            r_cnt       <= CW'(1);
          end else begin
            r_cnt <= w_cnt_inc;
            if (w_cnt_inc == STABLE_CNT) begin
              r_out    <= r_candidate;
              r_update <= 1'b1;
              r_state  <= IDLE;
            end
          end
        end
        default: r_state <= INIT;
      endcase
    end
  end

  saturating_counter #(
    .WIDTH(GLITCH_CNT_WIDTH)
  ) u_glitch_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (w_glitch_inc),
    .count(glitch_count)
  );

  assign out       = r_out;
  assign out_valid = r_out_valid;
  assign update    = r_update;
  assign unstable  = (r_state != IDLE);

endmodule

// File: tb/tb_bus_stability_filter.sv
// Drives three filter configurations from one bus and scoreboards them against a run-length model.
module tb_bus_stability_filter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_sync = 8'h5A;

  logic [7:0] out0, out1, out2;
  logic [2:0] vld, upd, uns;
  logic [7:0] g0, g1;
  logic [1:0] g2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_stability_filter #(.WIDTH(8), .STABLE_CYCLES(4), .RESET_VALUE(8'h00), .GLITCH_CNT_WIDTH(8)) u_d0 (
    .clk(clk), .rst(rst), .in_sync(in_sync), .out(out0), .out_valid(vld[0]),
    .update(upd[0]), .unstable(uns[0]), .glitch_count(g0));
  bus_stability_filter #(.WIDTH(8), .STABLE_CYCLES(1), .RESET_VALUE(8'h00), .GLITCH_CNT_WIDTH(8)) u_d1 (
    .clk(clk), .rst(rst), .in_sync(in_sync), .out(out1), .out_valid(vld[1]),
    .update(upd[1]), .unstable(uns[1]), .glitch_count(g1));
  bus_stability_filter #(.WIDTH(8), .STABLE_CYCLES(3), .RESET_VALUE(8'h3C), .GLITCH_CNT_WIDTH(2)) u_d2 (
    .clk(clk), .rst(rst), .in_sync(in_sync), .out(out2), .out_valid(vld[2]),
    .update(upd[2]), .unstable(uns[2]), .glitch_count(g2));

  // Model: track the current run of identical samples; a run reaching S commits if it
  // differs from the published word (or if nothing is published yet). Any break of a
  // run that differs from the published word, after the first commit, is a glitch.
  typedef struct {
    logic [7:0] out;
    bit         valid;
    logic [7:0] rv;
    int         rl;
    int         glitch;
  } mdl_t;

  mdl_t       m[3];
  int         s_cfg[3]  = '{4, 1, 3};
  int         gmax[3]   = '{255, 255, 3};
  logic [7:0] rv_cfg[3] = '{8'h00, 8'h00, 8'h3C};
  logic [7:0] q0[$], q1[$], q2[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int i, input logic [7:0] v);
    case (i)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic pop_exp(input int i, output logic [7:0] v, output bit ok);
    ok = 1'b0;
    v  = 8'h00;
    case (i)
      0: if (q0.size() > 0) begin v = q0.pop_front(); ok = 1'b1; end
      1: if (q1.size() > 0) begin v = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin v = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  function automatic logic [7:0] get_out(input int i);
    case (i)
      0: return out0;
      1: return out1;
      default: return out2;
    endcase
  endfunction

  function automatic logic [31:0] get_glitch(input int i);
    case (i)
      0: return {24'h0, g0};
      1: return {24'h0, g1};
      default: return {30'h0, g2};
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m[i].out    = rv_cfg[i];
      m[i].valid  = 1'b0;
      m[i].rv     = 8'h00;
      m[i].rl     = 0;
      m[i].glitch = 0;
    end
    q0.delete();
    q1.delete();
    q2.delete();
  endtask

  task automatic step(input int i, input logic [7:0] s);
    if ((m[i].rl == 0) || (s != m[i].rv)) begin
      if (m[i].valid && (m[i].rv != m[i].out) && (m[i].glitch < gmax[i]))
        m[i].glitch++;
      m[i].rv = s;
      m[i].rl = 1;
    end else begin
      m[i].rl++;
    end
    if ((m[i].rl == s_cfg[i]) && (!m[i].valid || (m[i].rv != m[i].out))) begin
      if (m[i].rv != m[i].out) push_exp(i, m[i].rv);
      m[i].out   = m[i].rv;
      m[i].valid = 1'b1;
    end
  endtask

  task automatic drive(input logic [7:0] v, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      in_sync = v;
      if (!rst) for (int i = 0; i < 3; i++) step(i, v);
    end
  endtask

  task automatic assert_reset();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("d%0d_async_rst_out", i), get_out(i), rv_cfg[i]);
      chk($sformatf("d%0d_async_rst_valid", i), vld[i], 1'b0);
      chk($sformatf("d%0d_async_rst_update", i), upd[i], 1'b0);
      chk($sformatf("d%0d_async_rst_unstable", i), uns[i], 1'b1);
    end
  endtask

  task automatic release_reset(input logic [7:0] v);
    @(negedge clk);
    rst = 1'b0;
    in_sync = v;
    for (int i = 0; i < 3; i++) step(i, v);
  endtask

  // Monitor: runs just after each rising edge, independent of the stimulus thread.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++) begin
      logic [7:0] e;
      bit         ok;
      if (upd[i]) begin
        pop_exp(i, e, ok);
        chk($sformatf("d%0d_update_expected", i), ok, 1'b1);
        if (ok) chk($sformatf("d%0d_update_value", i), get_out(i), e);
      end
      chk($sformatf("d%0d_out", i), get_out(i), m[i].out);
      chk($sformatf("d%0d_out_valid", i), vld[i], m[i].valid);
      chk($sformatf("d%0d_unstable", i), uns[i], (!m[i].valid || (m[i].rv != m[i].out)));
      chk($sformatf("d%0d_glitch_count", i), get_glitch(i), m[i].glitch);
    end
  end

  initial begin
    logic [7:0] pool[4];
    model_reset();
    pool = '{8'h5A, 8'hA5, 8'h50, 8'hFF};

    drive(8'h5A, 3);
    release_reset(8'h5A);
    drive(8'h5A, 5);
    // clean change
    drive(8'hA5, 6);
    // skewed intermediate word
    drive(8'h50, 1);
    drive(8'hA5, 6);
    // back to 5A, then revert after a 2-cycle excursion
    drive(8'h5A, 6);
    drive(8'hFF, 2);
    drive(8'h5A, 4);
    // repeated aborted settles to saturate the narrow counter
    for (int k = 0; k < 5; k++) begin
      drive(8'hFF, 2);
      drive(8'h5A, 2);
    end
    drive(8'h5A, 3);
    // reset while settling
    drive(8'hFF, 2);
    assert_reset();
    drive(8'h77, 2);
    release_reset(8'h01);
    drive(8'h01, 5);
    drive(8'h02, 5);

    for (int k = 0; k < 150; k++) begin
      logic [7:0] v;
      v = ($urandom_range(0, 4) == 0) ? 8'($urandom) : pool[$urandom_range(0, 3)];
      drive(v, $urandom_range(1, 5));
    end
    drive(in_sync, 6);
    @(negedge clk);

    chk("d0_queue_drained", q0.size(), 0);
    chk("d1_queue_drained", q1.size(), 0);
    chk("d2_queue_drained", q2.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_stability_filter.md
# bus_stability_filter

Downstream consumer of a per-bit two-flop synchronised multi-bit bus. Bits of a bus synchronised independently can land on different cycles, so the raw synchronised word may briefly show mixed old/new values. This block only accepts a new word after it has held the same value for `STABLE_CYCLES` consecutive clock edges. It then publishes the word on a registered output with a one-cycle `update` pulse, and counts aborted (glitched) settles for debug.

## Interface
- `WIDTH`, 8: bus width in bits, ≥1.
- `STABLE_CYCLES`, 4: consecutive identical samples required to commit, ≥1.
- `RESET_VALUE`, 0: value of `out` during and after reset until the first commit.
- `GLITCH_CNT_WIDTH`, 8: width of the debug glitch counter.

Ports (clock and reset first):
- `clk`  input  1  single clock, all logic on its rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `in_sync`  input  WIDTH  bus from the per-bit synchroniser, already in `clk` domain.
- `out`  output  WIDTH  filtered, committed word (registered).
- `out_valid`  output  1  high from the first commit after reset onward.
- `update`  output  1  one-cycle pulse when `out` takes a new value differing from its previous value.
- `unstable`  output  1  high while a candidate is settling (state INIT or SETTLE).
- `glitch_count`  output  GLITCH_CNT_WIDTH  saturating count of aborted settles.

## Operation
- Registers: `state`, `candidate[WIDTH]`, `cnt` (width `$clog2(STABLE_CYCLES+1)`), `out`, `out_valid`, `update`, `glitch_count`.
- Reset values: state=INIT, candidate=0, cnt=0, out=RESET_VALUE, out_valid=0, update=0, glitch_count=0. Consequently unstable=1 during and after reset.
- A "sample" is the value of `in_sync` at a rising edge.
- INIT, no commit yet:
  - Sample ≠ candidate, or cnt=0: candidate←sample, cnt←1.
  - Otherwise cnt←cnt+1.
  - When the updated cnt equals STABLE_CYCLES: out←candidate, out_valid←1, state←IDLE.
  - `update`=1 only if the committed value ≠ RESET_VALUE.
  - Mismatches in INIT do not increment `glitch_count`.
- IDLE:
  - Sample = out: stay.
  - Sample ≠ out: candidate←sample, cnt←1.
  - If STABLE_CYCLES=1, commit on that same edge and remain in IDLE. Otherwise state←SETTLE.
- SETTLE, checked in this priority order:
  1. Sample = out (reverted): state←IDLE, glitch_count+1, no update.
  2. Sample ≠ candidate: candidate←sample, cnt←1, glitch_count+1.
  3. Sample = candidate: cnt+1. On reaching STABLE_CYCLES: out←candidate, update←1, state←IDLE.
- `glitch_count` saturates at all-ones and never wraps.
- `update` is a registered pulse. It is cleared on every edge on which no commit occurs, so back-to-back commits yield back-to-back pulses.
- `unstable` is combinational from `state` (state ≠ IDLE).
- Reset mid-settle discards the candidate and returns to INIT. `out` reverts to RESET_VALUE immediately (asynchronous) and `out_valid` drops.

## Timing
- Latency:
  - A new value V first sampled at edge E commits at edge E+STABLE_CYCLES−1.
  - `out`=V and `update`=1 are visible in the cycle after that edge.
  - `update` lasts exactly one cycle.
- STABLE_CYCLES=1 is a pure registered pass-through: `out` follows `in_sync` by one cycle, with `update` on every change and no glitch counting.
- Minimum spacing between two commits is STABLE_CYCLES edges.
- No input handshake: the block samples every cycle. The upstream synchroniser's two-cycle delay is not included in these figures.

## Structure
- Shared package: state enum `bsf_state_t` {INIT, IDLE, SETTLE} and a helper function for the counter width.
- One natural sub-module: `saturating_counter` (parameter WIDTH; ports clk, rst, inc, count). Used for `glitch_count` and reusable elsewhere in domain_crossing.
- Intended instantiation: directly after the wide per-bit synchroniser, sharing its `clk`/`rst`.

## Test plan
- Reset: assert rst with in_sync=8'h5A → out=RESET_VALUE(0), out_valid=0, update=0, unstable=1, glitch_count=0. Release and hold 8'h5A for 4 edges → out=8'h5A, out_valid=1, update pulse 1 cycle.
- Clean change: from IDLE out=8'h5A, drive 8'hA5 steady → out=8'hA5 exactly 4 edges later, single update pulse, glitch_count unchanged.
- Skewed bits: drive 8'h5A→8'h50→8'hA5 (1 cycle at 8'h50) → no update at 8'h50, glitch_count=1, out=8'hA5 after 4 stable edges of 8'hA5.
- Revert: from out=8'h5A, drive 8'hFF for 2 cycles then back to 8'h5A → state returns to IDLE, no update, glitch_count+1, out stays 8'h5A.
- Saturation: with GLITCH_CNT_WIDTH=2, force 5 aborted settles → glitch_count=3, no wrap.
- Mid-settle reset and STABLE_CYCLES=1: assert rst during SETTLE → out=RESET_VALUE next instant, out_valid=0. With STABLE_CYCLES=1, in_sync 8'h01→8'h02 → out=8'h02 one cycle later with update.
